// File: rtl/xosera_pkg.sv
// Shared constants, payload structs and address helper for the tile fetch path.
package xosera_pkg;

  localparam int unsigned FONT_BANK_WORDS = 1024;
  localparam int unsigned TILE_W          = 8;
  localparam int unsigned TILE_H16        = 16;
  localparam int unsigned TILE_H8         = 8;

  localparam int unsigned TILE_ADDR_W = 12;
  localparam int unsigned TILE_DATA_W = 16;
  localparam int unsigned BANK_W      = 2;
  localparam int unsigned GLYPH_W     = 8;
  localparam int unsigned ROW_W       = 4;
  localparam int unsigned COLOR_W     = 4;

  typedef enum logic [1:0] {
    FETCH_IDLE,
    FETCH_READ,
    FETCH_CAPTURE
  } fetch_state_e;

  // Request payload as sampled on a transfer
  typedef struct packed {
    logic [BANK_W-1:0]  bank;
    logic               h16;
    logic [GLYPH_W-1:0] glyph;
    logic [ROW_W-1:0]   row;
    logic [COLOR_W-1:0] fg;
    logic [COLOR_W-1:0] bg;
  } tile_req_t;

  // One cell row ready for the pixel shifter
  typedef struct packed {
    logic [TILE_W-1:0]  bits;
    logic [COLOR_W-1:0] fg;
    logic [COLOR_W-1:0] bg;
  } pix_entry_t;

  // Word address of a glyph row; two rows share a word, result wraps at 4K words
  function automatic logic [TILE_ADDR_W-1:0] tile_addr(
    input logic [BANK_W-1:0]  bank,
    input logic [GLYPH_W-1:0] glyph,
    input logic [ROW_W-2:0]   row_hi,
    input logic               h16
  );
    if (h16) begin
      return TILE_ADDR_W'(32'(bank) * FONT_BANK_WORDS
                          + 32'(glyph) * (TILE_H16 / 2)
                          + 32'(row_hi));
    end else begin
      return TILE_ADDR_W'(32'(bank) * FONT_BANK_WORDS
                          + 32'(glyph) * (TILE_H8 / 2)
                          + 32'(row_hi[1:0]));
    end
  endfunction

endpackage

// File: rtl/tile_fetch_if.sv
// Request and pixel-stream bundle between a cell producer/consumer and tile_fetch.
interface tile_fetch_if;
  import xosera_pkg::*;

  logic               req_valid_i;
  logic               req_ready_o;
  logic [GLYPH_W-1:0] req_glyph_i;
  logic [ROW_W-1:0]   req_row_i;
  logic [COLOR_W-1:0] req_fg_i;
  logic [COLOR_W-1:0] req_bg_i;
  logic [BANK_W-1:0]  font_bank_i;
  logic               font_h16_i;

  logic               pix_valid_o;
  logic               pix_ready_i;
  logic [COLOR_W-1:0] pix_color_o;
  logic               pix_last_o;

  // Environment side: issues requests, consumes pixels
  modport master (
    output req_valid_i, req_glyph_i, req_row_i, req_fg_i, req_bg_i,
           font_bank_i, font_h16_i, pix_ready_i,
    input  req_ready_o, pix_valid_o, pix_color_o, pix_last_o
  );

  // Fetch unit side
  modport slave (
    input  req_valid_i, req_glyph_i, req_row_i, req_fg_i, req_bg_i,
           font_bank_i, font_h16_i, pix_ready_i,
    output req_ready_o, pix_valid_o, pix_color_o, pix_last_o
  );

endinterface

// File: rtl/tile_pix_shifter.sv
// Pixel shifter: serialises one cell row MSB first, fg for 1 bits, bg for 0 bits.
// TILE_FETCH_PIXDOUBLE_EN: each pixel is held for two beats (16 beats per cell).
module tile_pix_shifter
  import xosera_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n_i,
  input  logic               ld_valid,
  input  pix_entry_t         ld_data,
  output logic               ld_ready_c,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic [COLOR_W-1:0] pix_color,
  output logic               pix_last
);

`ifdef TILE_FETCH_PIXDOUBLE_EN
  localparam int unsigned PIX_REP = 2;
`else
  localparam int unsigned PIX_REP = 1;
`endif
  localparam int unsigned BEATS = TILE_W * PIX_REP;
  localparam int unsigned CNT_W = $clog2(BEATS);

  logic [TILE_W-1:0]  bits_q;
  logic [COLOR_W-1:0] fg_q;
  logic [COLOR_W-1:0] bg_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               valid_q;
  logic [COLOR_W-1:0] color_q;
  logic               last_q;

  logic               fire_c;
  logic               load_c;
  logic               advance_c;
  logic [CNT_W-1:0]   cnt_n_c;
  logic [TILE_W-1:0]  bits_n_c;

  // Accept a new row when idle or as the final beat leaves, so cells run back to back
  always_comb begin
    fire_c     = valid_q & pix_ready;
    ld_ready_c = ~valid_q | (fire_c & last_q);
    load_c     = ld_valid & ld_ready_c;
`ifdef TILE_FETCH_PIXDOUBLE_EN
    advance_c  = cnt_q[0];
`else
    advance_c  = 1'b1;
`endif
    cnt_n_c    = cnt_q + CNT_W'(1);
    bits_n_c   = advance_c ? (bits_q << 1) : bits_q;
  end

  // Shift register, beat counter and registered pixel outputs
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      bits_q  <= '0;
      fg_q    <= '0;
      bg_q    <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      color_q <= '0;
      last_q  <= 1'b0;
    end else if (load_c) begin
      bits_q  <= ld_data.bits;
      fg_q    <= ld_data.fg;
      bg_q    <= ld_data.bg;
      cnt_q   <= '0;
      valid_q <= 1'b1;
      color_q <= ld_data.bits[TILE_W-1] ? ld_data.fg : ld_data.bg;
      last_q  <= 1'b0;
    end else if (fire_c) begin
      if (last_q) begin
        valid_q <= 1'b0;
        color_q <= '0;
        last_q  <= 1'b0;
      end else begin
        bits_q  <= bits_n_c;
        cnt_q   <= cnt_n_c;
        color_q <= bits_n_c[TILE_W-1] ? fg_q : bg_q;
        last_q  <= (cnt_n_c == CNT_W'(BEATS - 1));
      end
    end
  end

  assign pix_valid = valid_q;
  assign pix_color = color_q;
  assign pix_last  = last_q;

endmodule

// File: rtl/tile_fetch.sv
// Tile fetch: turns a glyph/row request into a tile memory read and a pixel stream.
// TILE_FETCH_PIXDOUBLE_EN (in tile_pix_shifter) doubles every pixel; ports are unchanged.
module tile_fetch
  import xosera_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset_n_i,
  tile_fetch_if.slave            bus,
  output logic                   tile_rd_en_o,
  output logic [TILE_ADDR_W-1:0] tile_rd_addr_o,
  input  logic [TILE_DATA_W-1:0] tile_rd_data_i
);

  fetch_state_e           state_q;
  fetch_state_e           state_d;
  tile_req_t              req_c;
  logic                   xfer_c;
  logic                   ready_q;
  logic                   ready_d;
  logic                   rd_en_q;
  logic [TILE_ADDR_W-1:0] addr_q;
  logic                   row_lsb_q;
  logic [COLOR_W-1:0]     fg_q;
  logic [COLOR_W-1:0]     bg_q;

  pix_entry_t             hold_q;
  logic                   hold_full_q;
  logic                   hold_full_d;
  pix_entry_t             cap_c;
  logic                   cap_valid_c;
  pix_entry_t             ld_data_c;
  logic                   ld_valid_c;
  logic                   ld_ready_c;

  logic                   pix_valid;
  logic [COLOR_W-1:0]     pix_color;
  logic                   pix_last;

  assign req_c  = {bus.font_bank_i, bus.font_h16_i, bus.req_glyph_i,
                   bus.req_row_i, bus.req_fg_i, bus.req_bg_i};
  assign xfer_c = bus.req_valid_i & ready_q;

  // Fetch FSM next state
  always_comb begin
    state_d     = state_q;
    cap_valid_c = 1'b0;
    unique case (state_q)
      FETCH_IDLE:    if (xfer_c) state_d = FETCH_READ;
      FETCH_READ:    state_d = FETCH_CAPTURE;
      FETCH_CAPTURE: begin
        cap_valid_c = 1'b1;
        state_d     = FETCH_IDLE;
      end
      default:       state_d = FETCH_IDLE;
    endcase
  end

  // Captured row goes straight to the shifter if it can take it, else parks in the hold entry
  always_comb begin
    cap_c.bits  = row_lsb_q ? tile_rd_data_i[7:0] : tile_rd_data_i[15:8];
    cap_c.fg    = fg_q;
    cap_c.bg    = bg_q;
    ld_valid_c  = hold_full_q | cap_valid_c;
    ld_data_c   = hold_full_q ? hold_q : cap_c;
    hold_full_d = hold_full_q;
    if (hold_full_q && ld_ready_c) begin
      hold_full_d = 1'b0;
    end else if (cap_valid_c && !ld_ready_c) begin
      hold_full_d = 1'b1;
    end
    ready_d     = (state_d == FETCH_IDLE) && !hold_full_d;
  end

  // FSM state, request sampling and tile read port
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= FETCH_IDLE;
      ready_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      addr_q    <= '0;
      row_lsb_q <= 1'b0;
      fg_q      <= '0;
      bg_q      <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      rd_en_q <= (state_d == FETCH_READ);
      if (xfer_c) begin
        addr_q    <= tile_addr(req_c.bank, req_c.glyph, req_c.row[ROW_W-1:1], req_c.h16);
        row_lsb_q <= req_c.row[0];
        fg_q      <= req_c.fg;
        bg_q      <= req_c.bg;
      end
    end
  end

  // One-entry hold buffer
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      hold_full_q <= 1'b0;
      hold_q      <= '0;
    end else begin
      hold_full_q <= hold_full_d;
      if (cap_valid_c && !ld_ready_c) hold_q <= cap_c;
    end
  end

  tile_pix_shifter u_shifter (
    .clk        (clk),
    .reset_n_i  (reset_n_i),
    .ld_valid   (ld_valid_c),
    .ld_data    (ld_data_c),
    .ld_ready_c (ld_ready_c),
    .pix_valid  (pix_valid),
    .pix_ready  (bus.pix_ready_i),
    .pix_color  (pix_color),
    .pix_last   (pix_last)
  );

  assign bus.req_ready_o = ready_q;
  assign bus.pix_valid_o = pix_valid;
  assign bus.pix_color_o = pix_color;
  assign bus.pix_last_o  = pix_last;
  assign tile_rd_en_o    = rd_en_q;
  assign tile_rd_addr_o  = addr_q;

endmodule

// File: tb/tb_tile_fetch.sv
// Scoreboard bench for tile_fetch: stimulus queues expected reads/pixels, monitors check them.
module tb_tile_fetch;
  import xosera_pkg::*;

`ifdef TILE_FETCH_PIXDOUBLE_EN
  localparam int REP = 2;
`else
  localparam int REP = 1;
`endif
  localparam int BEATS = 8 * REP;

  logic        clk = 1'b0;
  logic        reset_n_i = 1'b0;
  logic        tile_rd_en_o;
  logic [11:0] tile_rd_addr_o;
  logic [15:0] tile_rd_data_i;

  tile_fetch_if tfi ();

  tile_fetch dut (
    .clk            (clk),
    .reset_n_i      (reset_n_i),
    .bus            (tfi),
    .tile_rd_en_o   (tile_rd_en_o),
    .tile_rd_addr_o (tile_rd_addr_o),
    .tile_rd_data_i (tile_rd_data_i)
  );

  always #5 clk = ~clk;

  // Tile memory model, data one clock after the read enable
  logic [15:0] mem [4096];
  always @(posedge clk) if (tile_rd_en_o) tile_rd_data_i <= mem[tile_rd_addr_o];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;
  logic [4:0]  exp_pix [$];
  logic [11:0] exp_addr [$];
  int beat_cnt = 0, last_cnt = 0, first_beat_cyc = 0, last_beat_cyc = 0;
  int rd_cyc = 0, first_pix_cyc = 0;
  logic prev_valid = 1'b0, stall_q = 1'b0, stall_last = 1'b0;
  logic [3:0] stall_color = '0;
  logic [4:0] mon_e;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: read address, pixel beats and back-pressure stability
  always @(negedge clk) begin
    if (reset_n_i) begin
      if (tile_rd_en_o) begin
        rd_cyc = cyc;
        chk("rd_expected", int'(exp_addr.size() > 0), 1);
        if (exp_addr.size() > 0) chk("rd_addr", int'(tile_rd_addr_o), int'(exp_addr.pop_front()));
      end
      if (stall_q) begin
        chk("stall_valid", int'(tfi.pix_valid_o), 1);
        chk("stall_color", int'(tfi.pix_color_o), int'(stall_color));
        chk("stall_last", int'(tfi.pix_last_o), int'(stall_last));
      end
      stall_q     = tfi.pix_valid_o && !tfi.pix_ready_i;
      stall_color = tfi.pix_color_o;
      stall_last  = tfi.pix_last_o;
      if (tfi.pix_valid_o && !prev_valid) first_pix_cyc = cyc;
      prev_valid = tfi.pix_valid_o;
      if (tfi.pix_valid_o && tfi.pix_ready_i) begin
        if (beat_cnt == 0) first_beat_cyc = cyc;
        last_beat_cyc = cyc;
        beat_cnt++;
        if (tfi.pix_last_o) last_cnt++;
        chk("pix_expected", int'(exp_pix.size() > 0), 1);
        if (exp_pix.size() > 0) begin
          mon_e = exp_pix.pop_front();
          chk("pix_color", int'(tfi.pix_color_o), int'(mon_e[3:0]));
          chk("pix_last", int'(tfi.pix_last_o), int'(mon_e[4]));
        end
      end
    end else begin
      stall_q    = 1'b0;
      prev_valid = 1'b0;
    end
  end

  // Issue one request and queue its expected read address and pixel beats
  task automatic send(input logic [1:0] bank, input logic [7:0] glyph, input logic [3:0] row,
                      input logic h16, input logic [3:0] fg, input logic [3:0] bg,
                      input logic [11:0] addr_exp, input logic [7:0] bval, output int xcyc);
    int n = 0;
    @(negedge clk);
    tfi.font_bank_i = bank;
    tfi.req_glyph_i = glyph;
    tfi.req_row_i   = row;
    tfi.font_h16_i  = h16;
    tfi.req_fg_i    = fg;
    tfi.req_bg_i    = bg;
    tfi.req_valid_i = 1'b1;
    while (!tfi.req_ready_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("req_accept", int'(tfi.req_ready_o), 1);
    xcyc = cyc;
    exp_addr.push_back(addr_exp);
    for (int i = 7; i >= 0; i--)
      for (int r = 0; r < REP; r++)
        exp_pix.push_back({(i == 0 && r == REP - 1), (bval[i] ? fg : bg)});
    @(posedge clk);
    #1 tfi.req_valid_i = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_pix.size() != 0 || exp_addr.size() != 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pix", exp_pix.size(), 0);
    chk("drain_addr", exp_addr.size(), 0);
  endtask

  task automatic wait_beats(input int k);
    int n = 0;
    while (beat_cnt < k && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("beats_reached", int'(beat_cnt >= k), 1);
  endtask

  task automatic clear_counts();
    beat_cnt = 0;
    last_cnt = 0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, int'(tfi.req_ready_o), 0);
    chk({tag, "_rd_en"}, int'(tile_rd_en_o), 0);
    chk({tag, "_rd_addr"}, int'(tile_rd_addr_o), 0);
    chk({tag, "_pix_valid"}, int'(tfi.pix_valid_o), 0);
    chk({tag, "_pix_color"}, int'(tfi.pix_color_o), 0);
    chk({tag, "_pix_last"}, int'(tfi.pix_last_o), 0);
  endtask

  initial begin
    int x;
    for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
    mem[12'h823] = 16'hA55A;
    mem[12'hC11] = 16'h81FF;
    mem[12'h3FF] = 16'h3C96;
    tfi.req_valid_i = 1'b0;
    tfi.req_glyph_i = '0;
    tfi.req_row_i   = '0;
    tfi.req_fg_i    = '0;
    tfi.req_bg_i    = '0;
    tfi.font_bank_i = '0;
    tfi.font_h16_i  = 1'b0;
    tfi.pix_ready_i = 1'b1;

    // Reset state, then ready on the first clock after release
    repeat (3) @(posedge clk);
    #1 chk_reset_outputs("rst");
    #1 reset_n_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("ready_after_rst", int'(tfi.req_ready_o), 1);

    // 8x16 fetch, latency from an empty pipeline
    clear_counts();
    send(2'd2, 8'h04, 4'd7, 1'b1, 4'hF, 4'h1, 12'h823, 8'h5A, x);
    wait_drain();
    chk("lat_rd_en", rd_cyc, x + 1);
    chk("lat_first_pix", first_pix_cyc, x + 3);
    chk("t1_beats", beat_cnt, BEATS);
    chk("t1_lasts", last_cnt, 1);

    // 8x8 fetch, high byte
    send(2'd3, 8'h04, 4'd2, 1'b0, 4'h7, 4'h2, 12'hC11, 8'h81, x);
    wait_drain();

    // Address wrap: 3*1024 + 255*8 + 7 = 5119 -> 0x3FF
    send(2'd3, 8'hFF, 4'd15, 1'b1, 4'h5, 4'hA, 12'h3FF, 8'h96, x);
    wait_drain();

    // Back-pressure mid-cell
    clear_counts();
    send(2'd2, 8'h04, 4'd7, 1'b1, 4'hC, 4'h3, 12'h823, 8'h5A, x);
    wait_beats(3);
    @(posedge clk);
    #1 tfi.pix_ready_i = 1'b0;
    repeat (5) @(posedge clk);
    #1 tfi.pix_ready_i = 1'b1;
    wait_drain();
    chk("bp_beats", beat_cnt, BEATS);
    chk("bp_lasts", last_cnt, 1);

    // Streaming: four back-to-back cells, no gaps
    clear_counts();
    send(2'd2, 8'h04, 4'd7, 1'b1, 4'hF, 4'h1, 12'h823, 8'h5A, x);
    send(2'd3, 8'h04, 4'd2, 1'b0, 4'h7, 4'h2, 12'hC11, 8'h81, x);
    send(2'd3, 8'hFF, 4'd15, 1'b1, 4'h5, 4'hA, 12'h3FF, 8'h96, x);
    send(2'd2, 8'h04, 4'd6, 1'b1, 4'h9, 4'h6, 12'h823, 8'hA5, x);
    wait_drain();
    chk("stream_beats", beat_cnt, 4 * BEATS);
    chk("stream_lasts", last_cnt, 4);
    chk("stream_span", last_beat_cyc - first_beat_cyc, 4 * BEATS - 1);

    // Reset mid-cell discards the cell; next request gives a full fresh cell
    send(2'd3, 8'h04, 4'd2, 1'b0, 4'h7, 4'h2, 12'hC11, 8'h81, x);
    clear_counts();
    wait_beats(3);
    #2 reset_n_i = 1'b0;
    #1 chk_reset_outputs("midrst");
    exp_pix.delete();
    exp_addr.delete();
    @(posedge clk);
    #2 reset_n_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("ready_after_midrst", int'(tfi.req_ready_o), 1);
    clear_counts();
    send(2'd2, 8'h04, 4'd7, 1'b1, 4'hF, 4'h1, 12'h823, 8'h5A, x);
    wait_drain();
    chk("fresh_beats", beat_cnt, BEATS);
    chk("fresh_lasts", last_cnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
